// File: rtl/i_execute_stage_if.sv
// Bus between decode and the execute stage: ID/EX inputs, flush controls and the EX/MEM outputs.
// The master side drives the decoded instruction; the slave side is the execute stage.
interface i_execute_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  flush_id_ex;
    logic                  flush_ex_mem;
    logic [8:0]            control_bits_in;
    logic [DATA_W-1:0]     npc_in;
    logic [DATA_W-1:0]     read_data1;
    logic [DATA_W-1:0]     read_data2;
    logic [DATA_W-1:0]     sign_ext;
    logic [REG_ADDR_W-1:0] rt_in;
    logic [REG_ADDR_W-1:0] rd_in;

    logic [1:0]            wb_ctrl;
    logic [2:0]            m_ctrl;
    logic [DATA_W-1:0]     branch_target;
    logic                  zero;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] write_reg;

    modport master (
        output flush_id_ex, flush_ex_mem, control_bits_in, npc_in,
               read_data1, read_data2, sign_ext, rt_in, rd_in,
        input  wb_ctrl, m_ctrl, branch_target, zero, alu_result,
               write_data, write_reg
    );

    modport slave (
        input  flush_id_ex, flush_ex_mem, control_bits_in, npc_in,
               read_data1, read_data2, sign_ext, rt_in, rd_in,
        output wb_ctrl, m_ctrl, branch_target, zero, alu_result,
               write_data, write_reg
    );
endinterface

// File: rtl/i_execute_stage.sv
// Execute stage: ID/EX register, ALU with funct decode, branch target and destination select,
// then the EX/MEM register. Two-edge latency, one instruction per cycle, never stalls.
module i_execute_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    i_execute_stage_if.slave  ex_if
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_fn_e;

    // ID/EX register
    logic [8:0]            idex_ctrl_q, idex_ctrl_d;
    logic [DATA_W-1:0]     idex_npc_q;
    logic [DATA_W-1:0]     idex_rd1_q;
    logic [DATA_W-1:0]     idex_rd2_q;
    logic [DATA_W-1:0]     idex_imm_q;
    logic [REG_ADDR_W-1:0] idex_rt_q;
    logic [REG_ADDR_W-1:0] idex_rd_q;

    // EX/MEM register
    logic [1:0]            exmem_wb_q, exmem_wb_d;
    logic [2:0]            exmem_m_q, exmem_m_d;
    logic [DATA_W-1:0]     exmem_bt_q, exmem_bt_d;
    logic                  exmem_zero_q, exmem_zero_d;
    logic [DATA_W-1:0]     exmem_alu_q, exmem_alu_d;
    logic [DATA_W-1:0]     exmem_wd_q;
    logic [REG_ADDR_W-1:0] exmem_wr_q, exmem_wr_d;

    logic                  reg_dst;
    logic [1:0]            alu_op;
    logic                  alu_src;
    logic [DATA_W-1:0]     op_b;
    alu_fn_e               alu_fn;

    assign idex_ctrl_d = ex_if.flush_id_ex ? 9'd0 : ex_if.control_bits_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_ctrl_q <= '0;
            idex_npc_q  <= '0;
            idex_rd1_q  <= '0;
            idex_rd2_q  <= '0;
            idex_imm_q  <= '0;
            idex_rt_q   <= '0;
            idex_rd_q   <= '0;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_npc_q  <= ex_if.npc_in;
            idex_rd1_q  <= ex_if.read_data1;
            idex_rd2_q  <= ex_if.read_data2;
            idex_imm_q  <= ex_if.sign_ext;
            idex_rt_q   <= ex_if.rt_in;
            idex_rd_q   <= ex_if.rd_in;
        end
    end

    assign reg_dst = idex_ctrl_q[3];
    assign alu_op  = idex_ctrl_q[2:1];
    assign alu_src = idex_ctrl_q[0];
    assign op_b    = alu_src ? idex_imm_q : idex_rd2_q;

    // Only ALUOp 10 looks at funct; unknown functs and ALUOp 11 fall back to add.
    always_comb begin
        alu_fn = ALU_ADD;
        case (alu_op)
            2'b01: alu_fn = ALU_SUB;
            2'b10: begin
                case (idex_imm_q[5:0])
                    6'b100010: alu_fn = ALU_SUB;
                    6'b100100: alu_fn = ALU_AND;
                    6'b100101: alu_fn = ALU_OR;
                    6'b101010: alu_fn = ALU_SLT;
                    default:   alu_fn = ALU_ADD;
                endcase
            end
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        exmem_alu_d = '0;
        case (alu_fn)
            ALU_ADD: exmem_alu_d = idex_rd1_q + op_b;
            ALU_SUB: exmem_alu_d = idex_rd1_q - op_b;
            ALU_AND: exmem_alu_d = idex_rd1_q & op_b;
            ALU_OR:  exmem_alu_d = idex_rd1_q | op_b;
            ALU_SLT: exmem_alu_d = {{(DATA_W-1){1'b0}}, ($signed(idex_rd1_q) < $signed(op_b))};
            default: exmem_alu_d = idex_rd1_q + op_b;
        endcase
    end

    assign exmem_zero_d = (exmem_alu_d == '0);
    assign exmem_bt_d   = idex_npc_q + (idex_imm_q << 2);
    assign exmem_wr_d   = reg_dst ? idex_rd_q : idex_rt_q;
    assign exmem_wb_d   = ex_if.flush_ex_mem ? 2'b00  : idex_ctrl_q[8:7];
    assign exmem_m_d    = ex_if.flush_ex_mem ? 3'b000 : idex_ctrl_q[6:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_wb_q   <= '0;
            exmem_m_q    <= '0;
            exmem_bt_q   <= '0;
            exmem_zero_q <= 1'b0;
            exmem_alu_q  <= '0;
            exmem_wd_q   <= '0;
            exmem_wr_q   <= '0;
        end else begin
            exmem_wb_q   <= exmem_wb_d;
            exmem_m_q    <= exmem_m_d;
            exmem_bt_q   <= exmem_bt_d;
            exmem_zero_q <= exmem_zero_d;
            exmem_alu_q  <= exmem_alu_d;
            exmem_wd_q   <= idex_rd2_q;
            exmem_wr_q   <= exmem_wr_d;
        end
    end

    assign ex_if.wb_ctrl       = exmem_wb_q;
    assign ex_if.m_ctrl        = exmem_m_q;
    assign ex_if.branch_target = exmem_bt_q;
    assign ex_if.zero          = exmem_zero_q;
    assign ex_if.alu_result    = exmem_alu_q;
    assign ex_if.write_data    = exmem_wd_q;
    assign ex_if.write_reg     = exmem_wr_q;

endmodule
